matrix_controller: RTL and testbench
====================================

# matrix_controller

Main instruction decoder of the single-cycle datapath. Decodes the 6-bit opcode and 6-bit function field of the current instruction into the datapath control strobes and a 4-bit ALU operation code. Outputs are registered on the system clock so downstream muxes and the register file see glitch-free controls. Stateless apart from the output register; every instruction decodes independently.

## Interface
- No parameters.
- Clk  input  1  system clock; all outputs update on its rising edge.
- Rst  input  1  synchronous, active-low reset (sampled on rising Clk).
- Op  input  6  instruction opcode, bits [31:26].
- Fcn  input  6  function field, bits [5:0].
- ALUSrc  output  1  1 = ALU operand B is the extended immediate; 0 = rt register.
- ALUSrc2  output  1  1 = ALU operand A is the shamt field (shift/rotate); 0 = rs register.
- RegSl  output  1  immediate extension: 1 = zero-extend, 0 = sign-extend.
- RegDst  output  1  write destination: 1 = rd, 0 = rt.
- RegWrite  output  1  register-file write enable.
- ALUOp  output  4  ALU operation code (see Operation).
- MemRead  output  1  data-memory read enable.
- MemWrite  output  1  data-memory write enable.
- MemtoReg  output  1  1 = write-back data from memory; 0 = from ALU.
- Brnch  output  1  branch-on-not-equal request to PC logic.

## Operation
- ALUOp encoding: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 slt, 0101 sll, 0110 srl, 0111 rotr, 1000 clo, 1001 clz, 1010 mul; 1011-1111 unused.
- Op 000000 (R-type): RegDst=1, RegWrite=1, ALUSrc=0, RegSl=0, memory/branch strobes 0. Fcn 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt with ALUSrc2=0; Fcn 000000 sll, 000010 srl, 000110 rotr with ALUSrc2=1.
- Op 011100 (SPECIAL2): RegDst=1, RegWrite=1, ALUSrc=0, ALUSrc2=0. Fcn 100001 clo, 100000 clz, 000010 mul.
- Op 001000 addi: ALUSrc=1, RegSl=0, RegDst=0, RegWrite=1, ALUOp add.
- Op 001101 ori: ALUSrc=1, RegSl=1, RegDst=0, RegWrite=1, ALUOp or.
- Op 100011 lw: ALUSrc=1, RegSl=0, RegDst=0, RegWrite=1, MemRead=1, MemtoReg=1, ALUOp add.
- Op 101011 sw: ALUSrc=1, RegSl=0, MemWrite=1, RegWrite=0, ALUOp add.
- Op 000101 bne: Brnch=1, ALUSrc=0, RegWrite=0, ALUOp sub.
- Fcn is ignored for I-type opcodes (addi/ori/lw/sw/bne decode identically for any Fcn).
- Any signal not listed for an instruction is 0.
- Unrecognized Op, or unrecognized Fcn under Op 000000/011100: NOP — all outputs 0 (ALUOp 0000); RegWrite, MemWrite and Brnch must never assert.
- At most one of MemRead/MemWrite is ever 1; MemtoReg=1 only with MemRead=1.

## Timing
- Rising Clk with Rst=0: all outputs cleared to 0 (NOP), regardless of Op/Fcn.
- Rising Clk with Rst=1: outputs load decode(Op, Fcn) sampled at that edge; latency one cycle, throughput one instruction per cycle.
- Outputs hold between edges; input changes between edges have no effect until the next edge.
- Reset asserted mid-stream: the next edge yields NOP; first edge after release yields the decode of the then-present inputs.
- Back-to-back different instructions: each edge's outputs depend only on that edge's inputs; no residue from the previous instruction.

## Test plan
- Reset: Rst=0 with Op=100011 for 2 edges -> all outputs 0; release -> next edge MemRead=1, MemtoReg=1, RegWrite=1, ALUSrc=1, ALUOp=0000.
- R-type sweep: Op=000000, Fcn 100000/100010/100100/100101/101010/000000/000010/000110 -> ALUOp 0000/0001/0010/0011/0100/0101/0110/0111, RegDst=1, RegWrite=1, ALUSrc2=1 only for last three.
- SPECIAL2: Op=011100, Fcn 100001/100000/000010 -> ALUOp 1000/1001/1010, RegDst=1, RegWrite=1, ALUSrc=0.
- I-type with Fcn=100010: addi -> ALUSrc=1, RegSl=0, RegDst=0, RegWrite=1, ALUOp 0000; ori -> RegSl=1, ALUOp 0011; sw -> MemWrite=1, RegWrite=0; bne -> Brnch=1, ALUOp 0001, RegWrite=0.
- Switch-back: bne then Op=000000/Fcn=000000 then Op=011100/Fcn=000010 then Op=000000/Fcn=100101 -> Brnch clears, ALUOp 0101 (ALUSrc2=1), 1010 (ALUSrc2=0), 0011; each one edge after its input.
- Illegal: Op=111111 any Fcn, and Op=000000/Fcn=111111 -> all outputs 0.

Source files
------------

// File: rtl/matrix_controller.sv
// Main instruction decoder: turns opcode/function fields into registered
// datapath control strobes and a 4-bit ALU operation code.
module matrix_controller (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [5:0] Op,
    input  logic [5:0] Fcn,
    output logic       ALUSrc,
    output logic       ALUSrc2,
    output logic       RegSl,
    output logic       RegDst,
    output logic       RegWrite,
    output logic [3:0] ALUOp,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       Brnch
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_SPEC2 = 6'b011100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_SLT  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_ROTR = 4'b0111;
    localparam logic [3:0] ALU_CLO  = 4'b1000;
    localparam logic [3:0] ALU_CLZ  = 4'b1001;
    localparam logic [3:0] ALU_MUL  = 4'b1010;

    logic       alu_src_d, alu_src2_d, reg_sl_d, reg_dst_d, reg_write_d;
    logic [3:0] alu_op_d;
    logic       mem_read_d, mem_write_d, mem_to_reg_d, brnch_d;

    always_comb begin
        alu_src_d    = 1'b0;
        alu_src2_d   = 1'b0;
        reg_sl_d     = 1'b0;
        reg_dst_d    = 1'b0;
        reg_write_d  = 1'b0;
        alu_op_d     = ALU_ADD;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        mem_to_reg_d = 1'b0;
        brnch_d      = 1'b0;
        unique case (Op)
            OP_RTYPE: begin
                // An unknown function code must leave every strobe low (NOP).
                reg_dst_d   = 1'b1;
                reg_write_d = 1'b1;
                case (Fcn)
                    6'b100000: alu_op_d = ALU_ADD;
                    6'b100010: alu_op_d = ALU_SUB;
                    6'b100100: alu_op_d = ALU_AND;
                    6'b100101: alu_op_d = ALU_OR;
                    6'b101010: alu_op_d = ALU_SLT;
                    6'b000000: begin alu_op_d = ALU_SLL;  alu_src2_d = 1'b1; end
                    6'b000010: begin alu_op_d = ALU_SRL;  alu_src2_d = 1'b1; end
                    6'b000110: begin alu_op_d = ALU_ROTR; alu_src2_d = 1'b1; end
                    default: begin
                        reg_dst_d   = 1'b0;
                        reg_write_d = 1'b0;
                    end
                endcase
            end
            OP_SPEC2: begin
                reg_dst_d   = 1'b1;
                reg_write_d = 1'b1;
                case (Fcn)
                    6'b100001: alu_op_d = ALU_CLO;
                    6'b100000: alu_op_d = ALU_CLZ;
                    6'b000010: alu_op_d = ALU_MUL;
                    default: begin
                        reg_dst_d   = 1'b0;
                        reg_write_d = 1'b0;
                    end
                endcase
            end
            OP_ADDI: begin
                alu_src_d   = 1'b1;
                reg_write_d = 1'b1;
            end
            OP_ORI: begin
                alu_src_d   = 1'b1;
                reg_sl_d    = 1'b1;
                reg_write_d = 1'b1;
                alu_op_d    = ALU_OR;
            end
            OP_LW: begin
                alu_src_d    = 1'b1;
                reg_write_d  = 1'b1;
                mem_read_d   = 1'b1;
                mem_to_reg_d = 1'b1;
            end
            OP_SW: begin
                alu_src_d   = 1'b1;
                mem_write_d = 1'b1;
            end
            OP_BNE: begin
                brnch_d  = 1'b1;
                alu_op_d = ALU_SUB;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            ALUSrc   <= 1'b0;
            ALUSrc2  <= 1'b0;
            RegSl    <= 1'b0;
            RegDst   <= 1'b0;
            RegWrite <= 1'b0;
            ALUOp    <= ALU_ADD;
            MemRead  <= 1'b0;
            MemWrite <= 1'b0;
            MemtoReg <= 1'b0;
            Brnch    <= 1'b0;
        end else begin
            ALUSrc   <= alu_src_d;
            ALUSrc2  <= alu_src2_d;
            RegSl    <= reg_sl_d;
            RegDst   <= reg_dst_d;
            RegWrite <= reg_write_d;
            ALUOp    <= alu_op_d;
            MemRead  <= mem_read_d;
            MemWrite <= mem_write_d;
            MemtoReg <= mem_to_reg_d;
            Brnch    <= brnch_d;
        end
    end

endmodule

// File: tb/tb_matrix_controller.sv
// Directed bench for matrix_controller: hand-computed control vectors checked
// one edge after each instruction is presented.
module tb_matrix_controller;

    logic       Clk;
    logic       Rst;
    logic [5:0] Op;
    logic [5:0] Fcn;
    logic       ALUSrc, ALUSrc2, RegSl, RegDst, RegWrite;
    logic [3:0] ALUOp;
    logic       MemRead, MemWrite, MemtoReg, Brnch;

    int checks = 0;
    int errors = 0;

    matrix_controller dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Op       (Op),
        .Fcn      (Fcn),
        .ALUSrc   (ALUSrc),
        .ALUSrc2  (ALUSrc2),
        .RegSl    (RegSl),
        .RegDst   (RegDst),
        .RegWrite (RegWrite),
        .ALUOp    (ALUOp),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .MemtoReg (MemtoReg),
        .Brnch    (Brnch)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Vector layout: {ALUSrc, ALUSrc2, RegSl, RegDst, RegWrite, ALUOp[3:0],
    //                 MemRead, MemWrite, MemtoReg, Brnch}
    function automatic logic [12:0] mk(input logic src, input logic src2,
                                       input logic sl, input logic dst,
                                       input logic wr, input logic [3:0] aop,
                                       input logic mr, input logic mw,
                                       input logic m2r, input logic br);
        return {src, src2, sl, dst, wr, aop, mr, mw, m2r, br};
    endfunction

    localparam logic [12:0] NOP = 13'h0000;

    task automatic apply(input logic [5:0] op, input logic [5:0] fcn);
        Op  = op;
        Fcn = fcn;
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [12:0] expv);
        logic [12:0] obs;
        obs = {ALUSrc, ALUSrc2, RegSl, RegDst, RegWrite, ALUOp,
               MemRead, MemWrite, MemtoReg, Brnch};
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    initial begin
        Rst = 1'b0;
        Op  = 6'b100011;
        Fcn = 6'b000000;

        // Reset holds outputs at NOP even with lw on the inputs
        apply(6'b100011, 6'b000000); check("reset_edge1", NOP);
        apply(6'b100011, 6'b000000); check("reset_edge2", NOP);
        Rst = 1'b1;
        apply(6'b100011, 6'b000000); check("lw_after_reset", mk(1,0,0,0,1,4'b0000,1,0,1,0));

        // R-type sweep
        apply(6'b000000, 6'b100000); check("r_add",  mk(0,0,0,1,1,4'b0000,0,0,0,0));
        apply(6'b000000, 6'b100010); check("r_sub",  mk(0,0,0,1,1,4'b0001,0,0,0,0));
        apply(6'b000000, 6'b100100); check("r_and",  mk(0,0,0,1,1,4'b0010,0,0,0,0));
        apply(6'b000000, 6'b100101); check("r_or",   mk(0,0,0,1,1,4'b0011,0,0,0,0));
        apply(6'b000000, 6'b101010); check("r_slt",  mk(0,0,0,1,1,4'b0100,0,0,0,0));
        apply(6'b000000, 6'b000000); check("r_sll",  mk(0,1,0,1,1,4'b0101,0,0,0,0));
        apply(6'b000000, 6'b000010); check("r_srl",  mk(0,1,0,1,1,4'b0110,0,0,0,0));
        apply(6'b000000, 6'b000110); check("r_rotr", mk(0,1,0,1,1,4'b0111,0,0,0,0));

        // SPECIAL2
        apply(6'b011100, 6'b100001); check("s2_clo", mk(0,0,0,1,1,4'b1000,0,0,0,0));
        apply(6'b011100, 6'b100000); check("s2_clz", mk(0,0,0,1,1,4'b1001,0,0,0,0));
        apply(6'b011100, 6'b000010); check("s2_mul", mk(0,0,0,1,1,4'b1010,0,0,0,0));

        // I-type with an R-type-looking function field
        apply(6'b001000, 6'b100010); check("addi", mk(1,0,0,0,1,4'b0000,0,0,0,0));
        apply(6'b001101, 6'b100010); check("ori",  mk(1,0,1,0,1,4'b0011,0,0,0,0));
        apply(6'b100011, 6'b100010); check("lw",   mk(1,0,0,0,1,4'b0000,1,0,1,0));
        apply(6'b101011, 6'b100010); check("sw",   mk(1,0,0,0,0,4'b0000,0,1,0,0));
        apply(6'b000101, 6'b100010); check("bne",  mk(0,0,0,0,0,4'b0001,0,0,0,1));
        apply(6'b001101, 6'b000110); check("ori_fcn2", mk(1,0,1,0,1,4'b0011,0,0,0,0));

        // Switch-back: no residue from the previous instruction
        apply(6'b000000, 6'b000000); check("sb_sll", mk(0,1,0,1,1,4'b0101,0,0,0,0));
        apply(6'b011100, 6'b000010); check("sb_mul", mk(0,0,0,1,1,4'b1010,0,0,0,0));
        apply(6'b000000, 6'b100101); check("sb_or",  mk(0,0,0,1,1,4'b0011,0,0,0,0));

        // Outputs hold when inputs change between edges
        apply(6'b101011, 6'b000000);
        Op = 6'b000101;
        Fcn = 6'b111111;
        #3;
        check("hold_sw", mk(1,0,0,0,0,4'b0000,0,1,0,0));

        // Illegal encodings decode to NOP
        apply(6'b111111, 6'b000000); check("ill_op_f0",  NOP);
        apply(6'b111111, 6'b100000); check("ill_op_f20", NOP);
        apply(6'b000000, 6'b111111); check("ill_rfcn",   NOP);
        apply(6'b011100, 6'b111111); check("ill_s2fcn",  NOP);
        apply(6'b000001, 6'b100000); check("ill_op01",   NOP);

        // Reset asserted mid-stream, then released onto a new instruction
        apply(6'b001000, 6'b000000); check("mid_addi", mk(1,0,0,0,1,4'b0000,0,0,0,0));
        Rst = 1'b0;
        apply(6'b001000, 6'b000000); check("mid_reset", NOP);
        Rst = 1'b1;
        apply(6'b001101, 6'b000000); check("mid_release_ori", mk(1,0,1,0,1,4'b0011,0,0,0,0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
